ins_prefetch: RTL

Instruction prefetch stage between the instruction ROM and the CPU decode logic. Runs sequential fetch requests ahead of the core, captures ROM responses into a small in-order queue, and presents one instruction per cycle to the CPU through a valid/ready handshake. A redirect input from the CPU (branch/jump) flushes the queue, discards in-flight ROM responses, and restarts fetch at the new PC.

---
 rtl/cpu_pkg.sv | 23 ++
 rtl/ins_fifo.sv | 92 +++++++++
 rtl/ins_prefetch.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_pkg
// Purpose  : Shared CPU-side widths, reset fetch address and the prefetch
//            queue entry layout. Used by the CPU, the ROM and ins_prefetch.
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package cpu_pkg;

  localparam int ADDR_W = 16;
  localparam int INS_W  = 16;

  localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 16'h0000;

  // One prefetched instruction together with the word address it came from.
  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INS_W-1:0]  ins;
  } ins_entry_t;

endpackage
`default_nettype wire

// File: rtl/ins_fifo.sv
`default_nettype none
// ============================================================================
// Module   : ins_fifo
// Purpose  : Synchronous single-clock FIFO with occupancy count and a flush
//            input that empties it on the next edge (flush beats push).
// Ports    : clk, rst        clock, synchronous active-high reset
//            i_flush         drop all entries
//            i_push/i_wdata  write side
//            i_pop/o_rdata   read side (o_rdata is the current head)
//            o_count         number of stored entries
//            o_empty/o_full  occupancy flags
// Revision : 1.0  initial release
// ============================================================================
module ins_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_flush,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_wdata,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_rdata,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_empty,
  output logic                   o_full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             w_do_push;
  logic             w_do_pop;

  always_comb begin
    w_do_pop  = i_pop && (count_q != '0);
    // A push into a full FIFO is only legal when the head leaves the same cycle.
    w_do_push = i_push && ((count_q != FULL_CNT) || w_do_pop);
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (i_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (w_do_push) begin
        mem_d[wr_ptr_q] = i_wdata;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (w_do_pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign o_rdata = mem_q[rd_ptr_q];
  assign o_count = count_q;
  assign o_empty = (count_q == '0);
  assign o_full  = (count_q == FULL_CNT);

endmodule
`default_nettype wire

// File: rtl/ins_prefetch.sv
`default_nettype none
// ============================================================================
// Module   : ins_prefetch
// Purpose  : Instruction prefetch stage. Issues sequential word reads to the
//            instruction ROM ahead of the CPU, queues the in-order responses
//            and hands them to decode through a valid/ready handshake. A
//            redirect flushes the queue, discards stale ROM responses and
//            restarts fetch at the new PC.
// Ports    : clk, rst                  clock, synchronous active-high reset
//            rom_en/rom_addr           registered ROM read request
//            rom_dout/rom_vld          in-order ROM response
//            redirect/redirect_pc      CPU flush pulse and new fetch address
//            ins_valid/ins_data/ins_pc queue head presented to the CPU
//            ins_ready                 CPU accepts the head
// Revision : 1.0  initial release
// ============================================================================
module ins_prefetch
  import cpu_pkg::*;
#(
  parameter int                DEPTH    = 4,
  parameter int                MAX_OUT  = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [INS_W-1:0]  rom_dout,
  input  logic              rom_vld,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              ins_valid,
  output logic [INS_W-1:0]  ins_data,
  output logic [ADDR_W-1:0] ins_pc,
  input  logic              ins_ready
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int SUM_W = CNT_W + 1;
  localparam int OUT_W = $clog2(MAX_OUT + 1) + 1;
  localparam logic [OUT_W-1:0] MAX_OUT_C = OUT_W'(MAX_OUT);
  localparam logic [SUM_W-1:0] DEPTH_C   = SUM_W'(DEPTH);

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] resp_pc_q,  resp_pc_d;
  logic [OUT_W-1:0]  inflight_q, inflight_d;
  logic [OUT_W-1:0]  discard_q,  discard_d;
  logic              rom_en_q,   rom_en_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;

  logic              w_vld_keep;
  logic              w_vld_drop;
  logic [OUT_W-1:0]  w_outstanding;
  logic [SUM_W-1:0]  w_credit_sum;
  logic              w_issue;
  logic              w_push;
  logic              w_pop;
  logic [CNT_W-1:0]  w_fifo_count;
  logic              w_fifo_empty;
  logic              w_fifo_full;
  ins_entry_t        w_head;

  always_comb begin
    w_vld_drop    = rom_vld && (discard_q != '0);
    w_vld_keep    = rom_vld && (discard_q == '0);
    // Requests still owed by the ROM once this cycle's response is consumed,
    // counting both live and to-be-discarded ones so the ROM never sees more
    // than MAX_OUT outstanding reads.
    w_outstanding = inflight_q + discard_q - OUT_W'(rom_vld);
    // Queue credit: every live request must have a slot waiting for it.
    w_credit_sum  = SUM_W'(w_fifo_count) + SUM_W'(inflight_q);
    // The full check is redundant with the credit rule; it only protects the
    // queue against a ROM that returns unrequested data.
    w_issue       = !redirect && (w_outstanding < MAX_OUT_C) &&
                    (w_credit_sum < DEPTH_C) && !w_fifo_full;
    w_push        = w_vld_keep && !redirect;
    w_pop         = ins_valid && ins_ready;

    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    inflight_d = inflight_q;
    discard_d  = discard_q;
    rom_en_d   = w_issue;
    rom_addr_d = w_issue ? fetch_pc_q : rom_addr_q;

    if (redirect) begin
      fetch_pc_d = redirect_pc;
      resp_pc_d  = redirect_pc;
      inflight_d = '0;
      discard_d  = w_outstanding;
    end else begin
      if (w_issue) begin
        fetch_pc_d = fetch_pc_q + 1'b1;
      end
      if (w_push) begin
        resp_pc_d = resp_pc_q + 1'b1;
      end
      inflight_d = inflight_q - OUT_W'(w_vld_keep) + OUT_W'(w_issue);
      discard_d  = discard_q - OUT_W'(w_vld_drop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      inflight_q <= '0;
      discard_q  <= '0;
      rom_en_q   <= 1'b0;
      rom_addr_q <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
      rom_en_q   <= rom_en_d;
      rom_addr_q <= rom_addr_d;
    end
  end

  ins_fifo #(
    .WIDTH (ADDR_W + INS_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_flush (redirect),
    .i_push  (w_push),
    .i_wdata ({resp_pc_q, rom_dout}),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_count (w_fifo_count),
    .o_empty (w_fifo_empty),
    .o_full  (w_fifo_full)
  );

  assign rom_en    = rom_en_q;
  assign rom_addr  = rom_addr_q;
  assign ins_valid = !w_fifo_empty;
  // Head fields read as zero while empty so stale entries never leak out.
  assign ins_data  = ins_valid ? w_head.ins : '0;
  assign ins_pc    = ins_valid ? w_head.pc  : '0;

endmodule
`default_nettype wire
